fp_acc_to_fp16: RTL
===================

# fp_acc_to_fp16

Output stage after `fp_posit_mac`. It converts the 32-bit two's-complement fixed-point accumulator and its exponent (`fixed_point_out`, `exp_out`, `NaR_out`) into an IEEE-754 binary16 word for write-back. Normalisation is iterative, one left shift per cycle. Rounding is round-to-nearest-even. Overflow saturates to ±Inf. Underflow flushes to zero; subnormals are not produced.

## Interface
- `ACC_WIDTH`, 32: accumulator width; only 32 is supported.
- `ACC_FRAC`, 13: fractional bits of the accumulator LSB relative to `exp_in` (1.13 product format).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  one clock; reset is synchronous and active-high.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `acc_in`  in  ACC_WIDTH  signed accumulator. Value = acc_in × 2^(exp_in − 15 − ACC_FRAC).
- `exp_in`  in  5  unsigned FP16-biased exponent (bias 15) of the accumulator scale.
- `NaR_in`  in  1  accumulator is NaR.
- `fp_out`  out  16  binary16 result; held until the next `done`.
- `busy`  out  1  high while state ≠ IDLE.
- `done`  out  1  one-cycle pulse; `fp_out` is valid in this cycle.

## Operation
- States: IDLE, NORM, ROUND.
- IDLE, `start`=1:
  - Latch `sign`=acc_in[31], `mag`=|acc_in| as 32-bit unsigned (0x80000000 stays 0x80000000), `exp_in`, `cnt`=0.
  - If `NaR_in`: `fp_out`=0x7E00, `done`=1, stay IDLE. NaR has priority over zero.
  - Else if `mag`=0: `fp_out`=0x0000, `done`=1, stay IDLE.
  - Otherwise → NORM.
- NORM, each cycle:
  - If `mag`[31]=1 → ROUND.
  - Else `mag`<<=1, `cnt`+=1, stay in NORM. Guaranteed to stop by `cnt`=31.
- ROUND, one cycle:
  - `frac`=mag[30:21], guard G=mag[20], sticky S=|mag[19:0].
  - Round up iff G & (S | frac[0]).
  - Exponent E = 18 + exp_in − cnt, computed as a 7-bit signed value; range −13..49.
  - If rounding carries out of `frac`: `frac`=0, E+=1.
  - If E ≥ 31: `fp_out`={sign,5'h1F,10'h0} (±Inf).
  - Else if E ≤ 0: `fp_out`={sign,15'h0} (signed zero).
  - Else `fp_out`={sign,E[4:0],frac}.
  - Set `done`=1 and return to IDLE.
- `start` while `busy`=1 is ignored and has no effect on the conversion in flight.
- Inputs are sampled only at the IDLE `start` cycle. They may change afterwards.

## Timing
- Reset (`rst`=1 at an edge):
  - State goes to IDLE.
  - `fp_out`=0x0000, `busy`=0, `done`=0, internal regs cleared.
  - Any conversion in flight is abandoned with no `done`.
  - `rst` has priority over `start` in the same cycle.
- Let L = leading zeros of `mag` (0..31), and `start` be accepted at edge T.
  - Normal path: NORM occupies T+1..T+1+L, ROUND is at T+2+L, `done` is high in the cycle after edge T+2+L. Total latency L+3 cycles from `start` to the `done` cycle; max 34.
  - NaR/zero path: `done` is high in the cycle after edge T; latency 1; `busy` never rises.
- `done` is high for exactly one cycle. `fp_out` changes only on the edge that raises `done`.
- `busy` rises the cycle after an accepted normal `start`. It falls in the same cycle `done` rises.
- A new `start` is accepted in the `done` cycle (back-to-back operation).

## Test plan
- Basic positive: acc_in=0x00002000, exp_in=15 → fp_out=0x3C00 (1.0), L=18, `done` 21 cycles after `start`. Negative: acc_in=0xFFFFE000 → 0xBC00.
- Specials:
  - acc_in=0 → 0x0000 at latency 1.
  - NaR_in=1 with acc_in=0 → 0x7E00 at latency 1.
  - acc_in=0x80000000, exp_in=0 → L=0, E=18 → 0xC800.
- Rounding:
  - 0x00002004, exp 15 → 0x3C00 (tie, round to even).
  - 0x0000200C → 0x3C02 (tie, odd LSB rounds up).
  - 0x00003FFF → 0x4000 (carry increments exponent).
- Range:
  - acc_in=0x40000000, exp_in=31 → 0x7C00 (overflow).
  - acc_in=0x00000001, exp_in=0 → 0x0000.
  - acc_in=0xFFFFFFFF, exp_in=0 → 0x8000.
- Handshake: pulse `start` again at cycles 2 and 5 of a busy conversion → ignored, single `done`, correct result. `start` in the `done` cycle → second result follows with correct latency.
- Reset: assert `rst` during NORM → no `done`, `busy`=0 and `fp_out`=0x0000 the next cycle. Then a fresh `start` converts normally.

Source files
------------

// File: rtl/fp_acc_to_fp16.sv
// Converts a signed fixed-point accumulator plus FP16-biased scale exponent into
// an IEEE-754 binary16 word: iterative normalisation, RNE rounding, Inf saturation, flush-to-zero.
module fp_acc_to_fp16 #(
  parameter int ACC_WIDTH = 32,
  parameter int ACC_FRAC  = 13
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ACC_WIDTH-1:0] acc_in,
  input  logic [4:0]           exp_in,
  input  logic                 NaR_in,
  output logic [15:0]          fp_out,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           state_dbg
);

  // Exponent of the accumulator MSB relative to exp_in, after FP16 bias: 31 - ACC_FRAC.
  localparam int E_OFF = ACC_WIDTH - 1 - ACC_FRAC;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2
  } state_t;

  state_t      state;
  logic        sign;
  logic [31:0] mag;
  logic [4:0]  exp_r;
  logic [4:0]  cnt;

  logic [31:0]       abs_in;
  logic [9:0]        frac;
  logic              guard_bit;
  logic              sticky_bit;
  logic              rnd_up;
  logic [10:0]       frac_sum;
  logic signed [6:0] e_pre;
  logic signed [6:0] e_fin;
  logic [15:0]       fp_round;

  // 0x80000000 negates to itself, which is the correct unsigned magnitude.
  assign abs_in = acc_in[31] ? (~acc_in + 32'd1) : acc_in;

  always_comb begin
    frac       = mag[30:21];
    guard_bit  = mag[20];
    sticky_bit = |mag[19:0];
    rnd_up     = guard_bit & (sticky_bit | frac[0]);
    frac_sum   = {1'b0, frac} + {10'b0, rnd_up};
    e_pre      = $signed(7'(E_OFF)) + $signed({2'b00, exp_r}) - $signed({2'b00, cnt});
    e_fin      = e_pre + $signed({6'b0, frac_sum[10]});
    fp_round   = {sign, 5'h00, frac_sum[9:0]};
    if (e_fin >= 7'sd31)
      fp_round = {sign, 5'h1F, 10'h000};
    else if (e_fin <= 7'sd0)
      fp_round = {sign, 15'h0000};
    else
      fp_round = {sign, e_fin[4:0], frac_sum[9:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sign   <= 1'b0;
      mag    <= 32'd0;
      exp_r  <= 5'd0;
      cnt    <= 5'd0;
      fp_out <= 16'h0000;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sign  <= acc_in[31];
            mag   <= abs_in;
            exp_r <= exp_in;
            cnt   <= 5'd0;
            if (NaR_in) begin
              fp_out <= 16'h7E00;
              done   <= 1'b1;
            end else if (abs_in == 32'd0) begin
              fp_out <= 16'h0000;
              done   <= 1'b1;
            end else begin
              state <= NORM;
            end
          end
        end
        NORM: begin
          if (mag[31]) begin
            state <= ROUND;
          end else begin
            mag <= mag << 1;
            cnt <= cnt + 5'd1;
          end
        end
        ROUND: begin
          fp_out <= fp_round;
          done   <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule
